// File: rtl/pmesh_load_tracker.sv
// rtl/pmesh_load_tracker.sv - Outstanding-load tracker bridging a client port to P-Mesh NoC2 requests and NoC3 responses.
// Entries run FREE->PENDING->ISSUED->RETURNED->FREE; returned data queues in arrival order.
module pmesh_load_tracker #(
  parameter int         NUM_ENTRIES = 4,
  parameter int         MSHRID_W    = 8,
  parameter int         PADDR_W     = 40,
  parameter int         HOMEID_W    = 30,
  parameter int         RESP_W      = 512,
  parameter logic [7:0] LOAD_TYPE   = 8'd19,
  localparam int        IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [PADDR_W-1:0]  req_addr_i,
  input  logic [2:0]          req_size_i,
  input  logic [HOMEID_W-1:0] req_homeid_i,
  output logic                noc2_valid_o,
  input  logic                noc2_ready_i,
  output logic [7:0]          noc2_req_type_o,
  output logic [MSHRID_W-1:0] noc2_mshrid_o,
  output logic [PADDR_W-1:0]  noc2_address_o,
  output logic [2:0]          noc2_size_o,
  output logic [HOMEID_W-1:0] noc2_homeid_o,
  output logic [7:0]          noc2_write_mask_o,
  output logic [63:0]         noc2_data_0_o,
  output logic [63:0]         noc2_data_1_o,
  input  logic                noc3_valid_i,
  input  logic [MSHRID_W-1:0] noc3_mshrid_i,
  input  logic [RESP_W-1:0]   noc3_resp_data_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [IDX_W-1:0]    resp_tag_o,
  output logic [RESP_W-1:0]   resp_data_o,
  output logic [IDX_W:0]      outstanding_o,
  output logic                spurious_o
);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_PENDING,
    ST_ISSUED,
    ST_RETURNED
  } entry_state_e;

  entry_state_e        st_q [NUM_ENTRIES];
  entry_state_e        st_d [NUM_ENTRIES];
  logic [IDX_W:0]      outstanding_q, outstanding_d;
  logic                spurious_q;

  logic                noc2_valid_q;
  logic [IDX_W-1:0]    noc2_idx_q;
  logic [PADDR_W-1:0]  noc2_addr_q;
  logic [2:0]          noc2_size_q;
  logic [HOMEID_W-1:0] noc2_homeid_q;

  logic [RESP_W-1:0]   fifo_data_q [NUM_ENTRIES];
  logic [IDX_W-1:0]    fifo_tag_q  [NUM_ENTRIES];
  logic [IDX_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [IDX_W:0]      cnt_q;

  logic                any_free;
  logic [IDX_W-1:0]    alloc_idx;
  logic                accept, noc2_hs, noc3_in_range, push, pop;
  logic [IDX_W-1:0]    noc3_idx;

  // Descending scan so the last assignment wins with the lowest free index.
  always_comb begin
    any_free  = 1'b0;
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (st_q[i] == ST_FREE) begin
        any_free  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  assign req_ready_o   = any_free && (!noc2_valid_q || noc2_ready_i);
  assign accept        = req_valid_i && req_ready_o;
  assign noc2_hs       = noc2_valid_q && noc2_ready_i;

  assign noc3_in_range = (noc3_mshrid_i >> IDX_W) == '0;
  assign noc3_idx      = noc3_mshrid_i[IDX_W-1:0];
  assign push          = noc3_valid_i && noc3_in_range && (st_q[noc3_idx] == ST_ISSUED);

  assign resp_valid_o  = cnt_q != '0;
  assign resp_tag_o    = fifo_tag_q[rd_ptr_q];
  assign resp_data_o   = fifo_data_q[rd_ptr_q];
  assign pop           = resp_valid_o && resp_ready_i;

  // The four events in a cycle always target distinct entries.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) st_d[i] = st_q[i];
    if (accept)  st_d[alloc_idx]  = ST_PENDING;
    if (noc2_hs) st_d[noc2_idx_q] = ST_ISSUED;
    if (push)    st_d[noc3_idx]   = ST_RETURNED;
    if (pop)     st_d[resp_tag_o] = ST_FREE;
    outstanding_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (st_d[i] != ST_FREE) outstanding_d = outstanding_d + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) st_q[i] <= ST_FREE;
      outstanding_q <= '0;
      spurious_q    <= 1'b0;
      noc2_valid_q  <= 1'b0;
      noc2_idx_q    <= '0;
      noc2_addr_q   <= '0;
      noc2_size_q   <= '0;
      noc2_homeid_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) st_q[i] <= st_d[i];
      outstanding_q <= outstanding_d;
      if (noc3_valid_i && !push) spurious_q <= 1'b1;
      if (accept) begin
        noc2_valid_q  <= 1'b1;
        noc2_idx_q    <= alloc_idx;
        noc2_addr_q   <= req_addr_i;
        noc2_size_q   <= req_size_i;
        noc2_homeid_q <= req_homeid_i;
      end else if (noc2_hs) begin
        noc2_valid_q  <= 1'b0;
      end
      if (push) wr_ptr_q <= wr_ptr_q + IDX_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + IDX_W'(1);
      if (push && !pop)      cnt_q <= cnt_q + (IDX_W+1)'(1);
      else if (!push && pop) cnt_q <= cnt_q - (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= noc3_resp_data_i;
      fifo_tag_q[wr_ptr_q]  <= noc3_idx;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) begin
      assert (cnt_q != (IDX_W+1)'(NUM_ENTRIES))
        else $error("response FIFO overflow");
    end
  end
`endif

  assign noc2_valid_o      = noc2_valid_q;
  assign noc2_req_type_o   = LOAD_TYPE;
  assign noc2_mshrid_o     = MSHRID_W'(noc2_idx_q);
  assign noc2_address_o    = noc2_addr_q;
  assign noc2_size_o       = noc2_size_q;
  assign noc2_homeid_o     = noc2_homeid_q;
  assign noc2_write_mask_o = 8'd0;
  assign noc2_data_0_o     = 64'd0;
  assign noc2_data_1_o     = 64'd0;
  assign outstanding_o     = outstanding_q;
  assign spurious_o        = spurious_q;

endmodule

// File: tb/tb_pmesh_load_tracker.sv
// tb/tb_pmesh_load_tracker.sv - Directed and randomized self-checking bench for pmesh_load_tracker.
module tb_pmesh_load_tracker;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid_i, req_ready_o;
  logic [39:0]  req_addr_i;
  logic [2:0]   req_size_i;
  logic [29:0]  req_homeid_i;
  logic         noc2_valid_o, noc2_ready_i;
  logic [7:0]   noc2_req_type_o, noc2_mshrid_o, noc2_write_mask_o;
  logic [39:0]  noc2_address_o;
  logic [2:0]   noc2_size_o;
  logic [29:0]  noc2_homeid_o;
  logic [63:0]  noc2_data_0_o, noc2_data_1_o;
  logic         noc3_valid_i;
  logic [7:0]   noc3_mshrid_i;
  logic [511:0] noc3_resp_data_i;
  logic         resp_valid_o, resp_ready_i;
  logic [1:0]   resp_tag_o;
  logic [511:0] resp_data_o;
  logic [2:0]   outstanding_o;
  logic         spurious_o;

  int checks = 0;
  int errors = 0;

  pmesh_load_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_size_i(req_size_i), .req_homeid_i(req_homeid_i),
    .noc2_valid_o(noc2_valid_o), .noc2_ready_i(noc2_ready_i), .noc2_req_type_o(noc2_req_type_o),
    .noc2_mshrid_o(noc2_mshrid_o), .noc2_address_o(noc2_address_o), .noc2_size_o(noc2_size_o),
    .noc2_homeid_o(noc2_homeid_o), .noc2_write_mask_o(noc2_write_mask_o),
    .noc2_data_0_o(noc2_data_0_o), .noc2_data_1_o(noc2_data_1_o),
    .noc3_valid_i(noc3_valid_i), .noc3_mshrid_i(noc3_mshrid_i), .noc3_resp_data_i(noc3_resp_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_tag_o(resp_tag_o),
    .resp_data_o(resp_data_o), .outstanding_o(outstanding_o), .spurious_o(spurious_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid_i = 1'b0; req_addr_i = '0; req_size_i = '0; req_homeid_i = '0;
    noc2_ready_i = 1'b0; noc3_valid_i = 1'b0; noc3_mshrid_i = '0;
    noc3_resp_data_i = '0; resp_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({noc2_valid_o, resp_valid_o, outstanding_o, spurious_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got nv=%b rv=%b out=%0d sp=%b exp all 0", noc2_valid_o, resp_valid_o, outstanding_o, spurious_o);
    end
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready_o); end
    checks++;
    if ({noc2_write_mask_o, noc2_data_0_o, noc2_data_1_o, noc2_address_o} !== '0) begin
      errors++; $display("FAIL reset_noc2_fields got mask=%h addr=%h exp 0", noc2_write_mask_o, noc2_address_o);
    end
  endtask

  task automatic test_single_load();
    logic [511:0] d;
    do_reset();
    req_valid_i = 1'b1; req_addr_i = 40'h12_3456_7880; req_size_i = 3'd1; req_homeid_i = 30'h5;
    noc2_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    checks++;
    if ({noc2_valid_o, noc2_mshrid_o, noc2_req_type_o, noc2_address_o, noc2_size_o, noc2_homeid_o} !==
        {1'b1, 8'd0, 8'd19, 40'h12_3456_7880, 3'd1, 30'h5}) begin
      errors++;
      $display("FAIL single_noc2 got v=%b id=%0d type=%0d addr=%h size=%0d exp v=1 id=0 type=19 addr=1234567880 size=1",
               noc2_valid_o, noc2_mshrid_o, noc2_req_type_o, noc2_address_o, noc2_size_o);
    end
    checks++;
    if (outstanding_o !== 3'd1) begin errors++; $display("FAIL single_outstanding got %0d exp 1", outstanding_o); end
    tick();
    d = rand_data();
    noc3_valid_i = 1'b1; noc3_mshrid_i = 8'd0; noc3_resp_data_i = d;
    tick();
    noc3_valid_i = 1'b0;
    checks++;
    if ({resp_valid_o, resp_tag_o, resp_data_o} !== {1'b1, 2'd0, d}) begin
      errors++; $display("FAIL single_resp got v=%b tag=%0d exp v=1 tag=0 (data match %b)", resp_valid_o, resp_tag_o, resp_data_o == d);
    end
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    checks++;
    if ({resp_valid_o, outstanding_o} !== 4'b0) begin
      errors++; $display("FAIL single_pop got rv=%b out=%0d exp 0 0", resp_valid_o, outstanding_o);
    end
  endtask

  task automatic test_fill();
    do_reset();
    noc2_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1; req_addr_i = 40'(i * 64);
      #1;
      checks++;
      if (req_ready_o !== (i < 4)) begin errors++; $display("FAIL fill_ready_%0d got %b exp %b", i, req_ready_o, i < 4); end
      tick();
      checks++;
      if (i < 4 && {noc2_valid_o, noc2_mshrid_o} !== {1'b1, 8'(i)}) begin
        errors++; $display("FAIL fill_mshrid_%0d got v=%b id=%0d exp v=1 id=%0d", i, noc2_valid_o, noc2_mshrid_o, i);
      end else if (i == 4 && noc2_valid_o !== 1'b0) begin
        errors++; $display("FAIL fill_noc2_idle got %b exp 0", noc2_valid_o);
      end
    end
    req_valid_i = 1'b0;
    checks++;
    if (outstanding_o !== 3'd4) begin errors++; $display("FAIL fill_outstanding got %0d exp 4", outstanding_o); end
  endtask

  task automatic test_out_of_order();
    int order [4] = '{2, 0, 3, 1};
    logic [511:0] dat [4];
    for (int k = 0; k < 4; k++) begin
      dat[k] = rand_data();
      noc3_valid_i = 1'b1; noc3_mshrid_i = 8'(order[k]); noc3_resp_data_i = dat[k];
      tick();
    end
    noc3_valid_i = 1'b0;
    checks++;
    if ({resp_valid_o, outstanding_o, spurious_o} !== {1'b1, 3'd4, 1'b0}) begin
      errors++; $display("FAIL ooo_filled got rv=%b out=%0d sp=%b exp 1 4 0", resp_valid_o, outstanding_o, spurious_o);
    end
    resp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({resp_valid_o, resp_tag_o, resp_data_o} !== {1'b1, 2'(order[k]), dat[k]}) begin
        errors++; $display("FAIL ooo_pop_%0d got v=%b tag=%0d exp v=1 tag=%0d (data match %b)", k, resp_valid_o, resp_tag_o, order[k], resp_data_o == dat[k]);
      end
      tick();
    end
    resp_ready_i = 1'b0;
    checks++;
    if ({resp_valid_o, outstanding_o} !== 4'b0) begin
      errors++; $display("FAIL ooo_drained got rv=%b out=%0d exp 0 0", resp_valid_o, outstanding_o);
    end
  endtask

  task automatic test_noc2_stall();
    do_reset();
    req_valid_i = 1'b1; req_addr_i = 40'hAA_0000_0040; req_size_i = 3'd2; req_homeid_i = 30'h11;
    tick();
    req_addr_i = 40'hBB_0000_0080; req_size_i = 3'd4; req_homeid_i = 30'h22;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({req_ready_o, noc2_valid_o, noc2_mshrid_o, noc2_address_o, noc2_size_o, noc2_homeid_o} !==
          {1'b0, 1'b1, 8'd0, 40'hAA_0000_0040, 3'd2, 30'h11}) begin
        errors++; $display("FAIL stall_hold_%0d got rdy=%b v=%b id=%0d addr=%h exp rdy=0 v=1 id=0 addr=aa00000040", c, req_ready_o, noc2_valid_o, noc2_mshrid_o, noc2_address_o);
      end
      tick();
    end
    noc2_ready_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", req_ready_o); end
    tick();
    req_valid_i = 1'b0;
    checks++;
    if ({noc2_valid_o, noc2_mshrid_o, noc2_address_o, noc2_size_o} !== {1'b1, 8'd1, 40'hBB_0000_0080, 3'd4}) begin
      errors++; $display("FAIL stall_next got v=%b id=%0d addr=%h exp v=1 id=1 addr=bb00000080", noc2_valid_o, noc2_mshrid_o, noc2_address_o);
    end
    tick();
    checks++;
    if ({noc2_valid_o, outstanding_o} !== {1'b0, 3'd2}) begin
      errors++; $display("FAIL stall_after got v=%b out=%0d exp 0 2", noc2_valid_o, outstanding_o);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    noc3_valid_i = 1'b1; noc3_mshrid_i = 8'd7; noc3_resp_data_i = rand_data();
    #1;
    checks++;
    if (spurious_o !== 1'b0) begin errors++; $display("FAIL spur_early got %b exp 0", spurious_o); end
    tick();
    noc3_mshrid_i = 8'd1;
    checks++;
    if ({spurious_o, resp_valid_o, outstanding_o} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL spur_range got sp=%b rv=%b out=%0d exp 1 0 0", spurious_o, resp_valid_o, outstanding_o);
    end
    tick();
    noc3_valid_i = 1'b0;
    tick();
    checks++;
    if ({spurious_o, resp_valid_o, outstanding_o} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL spur_free got sp=%b rv=%b out=%0d exp 1 0 0", spurious_o, resp_valid_o, outstanding_o);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    noc2_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid_i = 1'b1; req_addr_i = 40'(i + 1);
      tick();
    end
    req_valid_i = 1'b0;
    tick();
    noc3_valid_i = 1'b1; noc3_mshrid_i = 8'd1; noc3_resp_data_i = rand_data();
    tick();
    noc3_valid_i = 1'b0;
    checks++;
    if ({resp_valid_o, outstanding_o} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL midrst_setup got rv=%b out=%0d exp 1 3", resp_valid_o, outstanding_o);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({noc2_valid_o, resp_valid_o, outstanding_o, spurious_o, noc2_address_o} !== '0) begin
      errors++; $display("FAIL midrst_cleared got nv=%b rv=%b out=%0d sp=%b exp all 0", noc2_valid_o, resp_valid_o, outstanding_o, spurious_o);
    end
    noc3_valid_i = 1'b1; noc3_mshrid_i = 8'd0;
    tick();
    noc3_valid_i = 1'b0;
    checks++;
    if ({spurious_o, resp_valid_o} !== 2'b10) begin
      errors++; $display("FAIL midrst_stale got sp=%b rv=%b exp 1 0", spurious_o, resp_valid_o);
    end
    req_valid_i = 1'b1; req_addr_i = 40'h40;
    tick();
    req_valid_i = 1'b0;
    checks++;
    if ({noc2_valid_o, noc2_mshrid_o} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL midrst_next got v=%b id=%0d exp v=1 id=0", noc2_valid_o, noc2_mshrid_o);
    end
  endtask

  // Reference model: busy/in-network sets, one pending NoC2 request, ordered response queue.
  typedef struct {
    int           tag;
    logic [511:0] data;
  } resp_t;

  task automatic test_random();
    bit           busy [4];
    bit           in_net [4];
    bit           exp_nv, exp_sp, exp_ready, free_exists;
    int           exp_id, nfree, lowest, cand[$];
    logic [39:0]  exp_addr;
    logic [2:0]   exp_size;
    logic [29:0]  exp_home;
    resp_t        rq[$];
    resp_t        r;
    do_reset();
    busy = '{default: 0}; in_net = '{default: 0};
    exp_nv = 0; exp_sp = 0; exp_id = 0; exp_addr = '0; exp_size = '0; exp_home = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      req_valid_i  = 1'($urandom_range(0, 1));
      req_addr_i   = 40'({$urandom, $urandom});
      req_size_i   = 3'($urandom_range(0, 7));
      req_homeid_i = 30'($urandom);
      noc2_ready_i = ($urandom_range(0, 3) != 0);
      resp_ready_i = 1'($urandom_range(0, 1));
      noc3_resp_data_i = rand_data();
      cand.delete();
      for (int i = 0; i < 4; i++) if (in_net[i]) cand.push_back(i);
      noc3_valid_i = 1'b0; noc3_mshrid_i = '0;
      if (cand.size() != 0 && $urandom_range(0, 2) != 0) begin
        noc3_valid_i = 1'b1; noc3_mshrid_i = 8'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 29) == 0) begin
        noc3_valid_i = 1'b1; noc3_mshrid_i = 8'($urandom_range(0, 7));
      end
      #1;
      nfree = 0; lowest = -1;
      for (int i = 3; i >= 0; i--) if (!busy[i]) begin nfree++; lowest = i; end
      free_exists = (nfree != 0);
      exp_ready = free_exists && (!exp_nv || noc2_ready_i);
      checks++;
      if (req_ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, req_ready_o, exp_ready); end
      checks++;
      if (noc2_valid_o !== exp_nv) begin errors++; $display("FAIL rnd_noc2_valid cyc %0d got %b exp %b", cyc, noc2_valid_o, exp_nv); end
      else if (exp_nv && {noc2_mshrid_o, noc2_address_o, noc2_size_o, noc2_homeid_o} !== {8'(exp_id), exp_addr, exp_size, exp_home}) begin
        errors++; $display("FAIL rnd_noc2_fields cyc %0d got id=%0d addr=%h exp id=%0d addr=%h", cyc, noc2_mshrid_o, noc2_address_o, exp_id, exp_addr);
      end
      checks++;
      if (resp_valid_o !== (rq.size() != 0)) begin errors++; $display("FAIL rnd_resp_valid cyc %0d got %b exp %b", cyc, resp_valid_o, rq.size() != 0); end
      else if (rq.size() != 0 && {resp_tag_o, resp_data_o} !== {2'(rq[0].tag), rq[0].data}) begin
        errors++; $display("FAIL rnd_resp_head cyc %0d got tag=%0d exp tag=%0d (data match %b)", cyc, resp_tag_o, rq[0].tag, resp_data_o == rq[0].data);
      end
      checks++;
      if (outstanding_o !== 3'(4 - nfree)) begin errors++; $display("FAIL rnd_outstanding cyc %0d got %0d exp %0d", cyc, outstanding_o, 4 - nfree); end
      checks++;
      if (spurious_o !== exp_sp) begin errors++; $display("FAIL rnd_spurious cyc %0d got %b exp %b", cyc, spurious_o, exp_sp); end
      // All decisions use pre-edge state; then apply them together.
      if (noc3_valid_i) begin
        if (noc3_mshrid_i < 4 && in_net[noc3_mshrid_i]) begin
          r.tag = int'(noc3_mshrid_i); r.data = noc3_resp_data_i;
          in_net[noc3_mshrid_i] = 0;
          rq.push_back(r);
        end else exp_sp = 1;
      end
      if (resp_valid_o && resp_ready_i && rq.size() != 0) begin
        r = rq.pop_front();
        busy[r.tag] = 0;
      end
      if (exp_nv && noc2_ready_i) begin in_net[exp_id] = 1; exp_nv = 0; end
      if (req_valid_i && exp_ready) begin
        busy[lowest] = 1; exp_nv = 1; exp_id = lowest;
        exp_addr = req_addr_i; exp_size = req_size_i; exp_home = req_homeid_i;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    test_reset();
    test_single_load();
    test_fill();
    test_out_of_order();
    test_noc2_stall();
    test_spurious();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
